lcd_num_disp: RTL
=================

LCD_NUM_DISP -- requirements
Module: lcd_num_disp

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits displayed (2..8).
REQ-002 Parameter FRAC_DIGITS, default 2: digits right of decimal point (0..NUM_DIGITS-1); 0 = no point emitted.
REQ-003 Parameter EN_CYCLES, default 2: en high width, clk cycles (>=1).
REQ-004 Parameter SETTLE_CYCLES, default 3: post-pulse wait for normal bytes (>=1).
REQ-005 Parameter CLR_CYCLES, default 10: post-pulse wait after clear byte 0x01 (>=1).
REQ-006 Parameter POWERUP_CYCLES, default 5: wait after reset before init (>=1).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 upd_valid  in  1  new value offered.
REQ-010 bcd  in  4*NUM_DIGITS  value, MS digit in MS nibble.
REQ-011 upd_ready  out  1  block idle, will accept upd_valid.
REQ-012 lcd_data  out  8  LCD DB7..DB0.
REQ-013 en  out  1  LCD enable strobe.
REQ-014 rs  out  1  0 = command, 1 = character.
REQ-015 wr  out  1  LCD R/W, constant 0 (write only).

Function
REQ-016 States: PWRUP, SETUP, PULSE, HOLD, IDLE; byte source is init table or frame sequencer.
REQ-017 Byte transaction: SETUP 1 cycle (en=0, rs/lcd_data valid), PULSE EN_CYCLES (en=1, same rs/data), HOLD SETTLE_CYCLES or CLR_CYCLES for 0x01 (en=0, rs/data held).
REQ-018 After reset: PWRUP for POWERUP_CYCLES, then init bytes rs=0: 0x38, 0x0C, 0x01, 0x06, then IDLE.
REQ-019 upd_ready=1 only in IDLE; transfer when upd_valid && upd_ready on a rising edge; bcd latched on that edge.
REQ-020 upd_valid while upd_ready=0 ignored; bcd changes after transfer do not affect the frame in progress.
REQ-021 Frame: 0x80 (rs=0); then rs=1: integer digits MS first, 0x2E if FRAC_DIGITS>0, fractional digits, 0x20, 0xDF, 0x43.
REQ-022 Digit nibble 0..9 -> 0x30+nibble; nibble 0xA..0xF -> 0x3F ('?').
REQ-023 First SETUP of frame in cycle after transfer edge; upd_ready returns 1 in cycle after final HOLD.
REQ-024 Frame length = 1 + NUM_DIGITS + (FRAC_DIGITS>0) + 3 bytes.
REQ-025 wr=0 in every state.

Reset
REQ-026 rst has priority over all inputs, including simultaneous upd_valid.
REQ-027 Reset values: en=0, rs=0, wr=0, lcd_data=0x00, upd_ready=0, all counters 0, state PWRUP.
REQ-028 rst mid-transaction: en drops next edge, frame discarded, full PWRUP+init rerun.

Configuration
REQ-029 Macro LCD_LEAD_ZERO_BLANK_EN defined: leading '0' integer digits emitted as 0x20, stopping at the first non-zero digit; the digit immediately left of the point (or the LS digit when FRAC_DIGITS=0) is never blanked.
REQ-030 LCD_LEAD_ZERO_BLANK_EN undefined: every digit emitted per REQ-022; frame length unchanged either way.

Verification (defaults: byte = 6 cycles, clear = 13 cycles)
REQ-031 Release rst, upd_valid=0 -> en stays 0 for 5 cycles; bytes 0x38, 0x0C, 0x01, 0x06 (rs=0); each en pulse 2 cycles; upd_ready=1 at cycle 36.
REQ-032 bcd=0x0235 transfer, LCD_LEAD_ZERO_BLANK_EN defined -> 0x80, 0x20, 0x32, 0x2E, 0x33, 0x35, 0x20, 0xDF, 0x43; upd_ready=0 for 54 cycles.
REQ-033 Same stimulus with LCD_LEAD_ZERO_BLANK_EN undefined -> second byte 0x30; bcd=0x0005 defined -> 0x20, 0x30, 0x2E, 0x30, 0x35.
REQ-034 bcd=0x1A99 -> digit bytes 0x31, 0x3F, 0x39, 0x39; upd_valid pulses with bcd=0x7777 mid-frame -> no second frame, output unchanged.
REQ-035 rst asserted during PULSE of 4th frame byte -> en=0 next edge, lcd_data=0x00; full init sequence repeats as REQ-031.
REQ-036 NUM_DIGITS=3, FRAC_DIGITS=0, bcd=0x123 -> 0x80, 0x31, 0x32, 0x33, 0x20, 0xDF, 0x43, no 0x2E; upd_ready low 42 cycles.

Source files
------------

// File: rtl/lcd_num_disp_if.sv
// Update handshake plus HD44780-style LCD write bus for lcd_num_disp.
// The master side offers BCD values; the slave side drives the LCD pins.
interface lcd_num_disp_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    upd_valid;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    upd_ready;
    logic [7:0]              lcd_data;
    logic                    en;
    logic                    rs;
    logic                    wr;

    modport master (
        output upd_valid, bcd,
        input  upd_ready, lcd_data, en, rs, wr
    );

    modport slave (
        input  upd_valid, bcd,
        output upd_ready, lcd_data, en, rs, wr
    );
endinterface

// File: rtl/lcd_num_disp.sv
// Writes a fixed-point BCD value followed by " degC" to a character LCD.
// Optional feature macro: LCD_LEAD_ZERO_BLANK_EN blanks leading integer zeros.
module lcd_num_disp #(
    parameter int NUM_DIGITS     = 4,
    parameter int FRAC_DIGITS    = 2,
    parameter int EN_CYCLES      = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int CLR_CYCLES     = 10,
    parameter int POWERUP_CYCLES = 5
) (
    input logic          clk,
    input logic          rst,
    lcd_num_disp_if.slave bus
);
    localparam int INT_DIGITS = NUM_DIGITS - FRAC_DIGITS;
    localparam int HAS_PT     = (FRAC_DIGITS > 0) ? 1 : 0;
    localparam int FRAME_LEN  = NUM_DIGITS + HAS_PT + 4;
    localparam int BW         = 4 * NUM_DIGITS;

    localparam logic [15:0] PWRUP_LAST  = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] EN_LAST     = 16'(EN_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CLR_LAST    = 16'(CLR_CYCLES - 1);
    localparam logic [3:0]  FRAME_LAST  = 4'(FRAME_LEN - 1);
    localparam logic [3:0]  INIT_LAST   = 4'd3;

    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, IDLE} state_t;

    state_t         state_q;
    logic [15:0]    cnt_q;
    logic [3:0]     idx_q;
    logic           frame_q;
    logic           en_q;
    logic           rs_q;
    logic [7:0]     data_q;
    logic           ready_q;
    logic [BW-1:0]  bcd_q;

    logic [3:0]     idx_d;
    logic [7:0]     data_d;
    logic           last_d;
    logic [15:0]    hold_last_d;

    function automatic logic [7:0] digit_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

`ifdef LCD_LEAD_ZERO_BLANK_EN
    // Digit k is blanked when it and every digit to its left are zero,
    // except the units digit, which always shows.
    function automatic logic is_lead_zero(input logic [BW-1:0] v, input int k);
        logic z;
        z = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j <= k && v[4*(NUM_DIGITS-1-j) +: 4] != 4'h0) z = 1'b0;
        return z && (k < INT_DIGITS - 1);
    endfunction
`endif

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Frame layout: cursor home, integer digits, optional point, fraction, " ", deg, "C".
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [BW-1:0] v);
        int i;
        int k;
        i = int'(idx);
        k = 0;
        if (i == 0) return 8'h80;
        if (i <= INT_DIGITS) begin
            k = i - 1;
`ifdef LCD_LEAD_ZERO_BLANK_EN
            if (is_lead_zero(v, k)) return 8'h20;
`endif
            return digit_char(v[4*(NUM_DIGITS-1-k) +: 4]);
        end
        if (HAS_PT == 1 && i == INT_DIGITS + 1) return 8'h2E;
        if (i <= NUM_DIGITS + HAS_PT) begin
            k = i - 1 - HAS_PT;
            return digit_char(v[4*(NUM_DIGITS-1-k) +: 4]);
        end
        if (i == NUM_DIGITS + HAS_PT + 1) return 8'h20;
        if (i == NUM_DIGITS + HAS_PT + 2) return 8'hDF;
        return 8'h43;
    endfunction

    always_comb begin
        idx_d       = idx_q + 4'd1;
        data_d      = frame_q ? frame_byte(idx_d, bcd_q) : init_byte(idx_d);
        last_d      = frame_q ? (idx_q == FRAME_LAST) : (idx_q == INIT_LAST);
        hold_last_d = (data_q == 8'h01) ? CLR_LAST : SETTLE_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWRUP;
            cnt_q   <= 16'd0;
            idx_q   <= 4'd0;
            frame_q <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_q == PWRUP_LAST) begin
                        state_q <= SETUP;
                        cnt_q   <= 16'd0;
                        idx_q   <= 4'd0;
                        frame_q <= 1'b0;
                        rs_q    <= 1'b0;
                        data_q  <= init_byte(4'd0);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                SETUP: begin
                    state_q <= PULSE;
                    en_q    <= 1'b1;
                    cnt_q   <= 16'd0;
                end
                PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        state_q <= HOLD;
                        en_q    <= 1'b0;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == hold_last_d) begin
                        cnt_q <= 16'd0;
                        if (last_d) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            idx_q   <= idx_d;
                            data_q  <= data_d;
                            // Only the cursor command at index 0 of a frame is rs=0.
                            rs_q    <= frame_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                IDLE: begin
                    if (bus.upd_valid) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        bcd_q   <= bus.bcd;
                        frame_q <= 1'b1;
                        idx_q   <= 4'd0;
                        rs_q    <= 1'b0;
                        data_q  <= 8'h80;
                    end
                end
                default: state_q <= PWRUP;
            endcase
        end
    end

    assign bus.upd_ready = ready_q;
    assign bus.lcd_data  = data_q;
    assign bus.en        = en_q;
    assign bus.rs        = rs_q;
    assign bus.wr        = 1'b0;
endmodule
